div_nbit_seq: RTL and testbench



---
 rtl/div_nbit_seq_if.sv | 39 +++
 rtl/div_nbit_seq.sv | 86 ++++++++
 tb/tb_div_nbit_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/div_nbit_seq_if.sv
// Operand/result handshake bundle for the
// sequential unsigned divider.
interface div_nbit_seq_if #(
  parameter int n = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] dividend;
  logic [n-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] quotient;
  logic [n-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/div_nbit_seq.sv
// Radix-2 restoring divider, one trial
// subtraction per cycle, one op in flight.
module div_nbit_seq #(
  parameter int n = 8
) (
  input logic          clk,
  input logic          rst,
  div_nbit_seq_if.slave bus
);
  localparam int cw = $clog2(n + 1);
  localparam logic [cw-1:0] last = cw'(n - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t       state;
  logic [cw-1:0] cnt;
  logic [n-1:0] q;
  logic [n-1:0] dsr;
  logic [n-1:0] r;
  logic         dbz;

  // The remainder register stays below the
  // divisor, so n bits hold it; the shifted
  // trial value needs n+1 bits so a full
  // scale operand cannot overflow.
  logic [n:0] r_sh;
  logic [n:0] diff;

  assign r_sh = {r, q[n-1]};
  assign diff = r_sh - {1'b0, dsr};

  // Control FSM plus shift/subtract datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      dsr   <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor == '0) begin
              q     <= '1;
              r     <= bus.dividend;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              q     <= bus.dividend;
              dsr   <= bus.divisor;
              r     <= '0;
              cnt   <= '0;
              dbz   <= 1'b0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          q   <= {q[n-2:0], ~diff[n]};
          r   <= diff[n] ? r_sh[n-1:0]
                         : diff[n-1:0];
          cnt <= cnt + cw'(1);
          if (cnt == last)
            state <= DONE;
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q;
  assign bus.remainder   = r;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_div_nbit_seq.sv
// Directed and swept checks of the
// sequential divider at n=8 and n=4.
module tb_div_nbit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  div_nbit_seq_if #(.n(8)) bus8 ();
  div_nbit_seq_if #(.n(4)) bus4 ();

  div_nbit_seq #(.n(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  div_nbit_seq #(.n(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  logic       sel  = 1'b0;
  logic       iv   = 1'b0;
  logic       ordy = 1'b1;
  logic [7:0] a    = '0;
  logic [7:0] b    = '0;

  assign bus8.in_valid  = iv & ~sel;
  assign bus8.dividend  = a;
  assign bus8.divisor   = b;
  assign bus8.out_ready = ordy;
  assign bus4.in_valid  = iv & sel;
  assign bus4.dividend  = a[3:0];
  assign bus4.divisor   = b[3:0];
  assign bus4.out_ready = ordy;

  logic       ir;
  logic       ov;
  logic       dz;
  logic [7:0] q;
  logic [7:0] r;

  assign ir = sel ? bus4.in_ready : bus8.in_ready;
  assign ov = sel ? bus4.out_valid : bus8.out_valid;
  assign dz = sel ? bus4.div_by_zero
                  : bus8.div_by_zero;
  assign q  = sel ? {4'b0, bus4.quotient}
                  : bus8.quotient;
  assign r  = sel ? {4'b0, bus4.remainder}
                  : bus8.remainder;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_ir"}, ir, 1);
    check({tag, "_ov"}, ov, 0);
    check({tag, "_q"}, q, 0);
    check({tag, "_r"}, r, 0);
    check({tag, "_dz"}, dz, 0);
  endtask

  // One transaction; ex_q/ex_r are given
  // by the caller, hold = cycles with
  // out_ready low after out_valid rises.
  task automatic run(input logic [7:0] da,
                     input logic [7:0] db,
                     input logic [7:0] ex_q,
                     input logic [7:0] ex_r,
                     input int hold);
    int k;
    int w;
    logic ez;
    w  = sel ? 4 : 8;
    ez = (db == 8'd0);
    k  = 0;
    while (!ir && k < 100) begin
      step;
      k++;
    end
    check("ready_wait", ir, 1);
    a    = da;
    b    = db;
    iv   = 1'b1;
    ordy = (hold == 0);
    step;
    iv = 1'b0;
    a  = 8'($urandom);
    b  = 8'($urandom);
    k  = 1;
    while (!ov && k < 40) begin
      step;
      k++;
    end
    check("latency", k, ez ? 1 : w + 1);
    check("quot", q, ex_q);
    check("rem", r, ex_r);
    check("dbz", dz, ez);
    check("ir_low", ir, 0);
    for (int h = 0; h < hold; h++) begin
      step;
      check("hold_ov", ov, 1);
      check("hold_ir", ir, 0);
      check("hold_q", q, ex_q);
      check("hold_r", r, ex_r);
    end
    ordy = 1'b1;
    step;
    check("back_idle", ir, 1);
    check("ov_clear", ov, 0);
  endtask

  task automatic run_ref(input logic [7:0] da,
                         input logic [7:0] db);
    logic [7:0] m;
    m = sel ? 8'h0F : 8'hFF;
    if (db == 8'd0)
      run(da, db, m, da, 0);
    else
      run(da, db, da / db, da % db, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    step;
    step;
    rst = 1'b0;
    sel = 1'b0;
    expect_reset("rst8");
    sel = 1'b1;
    expect_reset("rst4");
    sel = 1'b0;

    run(8'd100, 8'd7, 8'd14, 8'd2, 0);
    run(8'd255, 8'd1, 8'd255, 8'd0, 0);
    run(8'd255, 8'd255, 8'd1, 8'd0, 0);
    run(8'd5, 8'd9, 8'd0, 8'd5, 0);
    run(8'd37, 8'd0, 8'hFF, 8'd37, 0);
    run(8'd12, 8'd4, 8'd3, 8'd0, 0);
    run(8'd200, 8'd3, 8'd66, 8'd2, 5);

    a  = 8'd50;
    b  = 8'd3;
    iv = 1'b1;
    step;
    iv = 1'b0;
    step;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    expect_reset("midrst");
    for (int i = 0; i < 12; i++) begin
      step;
      check("no_stale", ov, 0);
    end
    run(8'd9, 8'd2, 8'd4, 8'd1, 0);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? 8'd0
                        : 8'($urandom);
      run_ref(ra, rb);
    end

    sel = 1'b1;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_ref(8'(x), 8'(y));
    run(8'd15, 8'd1, 8'd15, 8'd0, 0);
    run(8'd13, 8'd0, 8'd15, 8'd13, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
